// File: rtl/regfile_read_port.sv
// Registered dual-operand read port for the 32x32 register file.
// Two operands are selected per accepted request. A same-cycle write is
// bypassed into the result. Responses are held in a main + skid buffer, so
// the consumer can stall without dropping an accepted request.
module regfile_read_port #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REGS*DATA_W-1:0] rows,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [ADDR_W-1:0]          req_ra,
    input  logic [ADDR_W-1:0]          req_rb,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_a,
    output logic [DATA_W-1:0]          rsp_b
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } buf_state_e;

    buf_state_e        state_q, state_d;
    logic [DATA_W-1:0] main_a_q, main_a_d;
    logic [DATA_W-1:0] main_b_q, main_b_d;
    logic [DATA_W-1:0] skid_a_q, skid_a_d;
    logic [DATA_W-1:0] skid_b_q, skid_b_d;
    logic              ready_q, ready_d;

    logic              accept;
    logic              transfer;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Zero register and unmapped addresses read 0; otherwise a same-cycle
    // write wins over the stored row contents.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0]          addr,
        input logic [NUM_REGS*DATA_W-1:0] rows_v,
        input logic                       we,
        input logic [ADDR_W-1:0]          wa,
        input logic [DATA_W-1:0]          wd
    );
        logic [DATA_W-1:0] val;
        logic              hit;
        val = '0;
        hit = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (addr == ADDR_W'(r)) begin
                val = rows_v[r*DATA_W +: DATA_W];
                hit = 1'b1;
            end
        end
        if (!hit || addr == ADDR_W'(ZERO_REG)) begin
            val = '0;
        end else if (we && wa == addr) begin
            val = wd;
        end
        return val;
    endfunction

    // Operand selection for the current request.
    always_comb begin
        op_a = sel_operand(req_ra, rows, wr_en, wr_addr, wr_data);
        op_b = sel_operand(req_rb, rows, wr_en, wr_addr, wr_data);
    end

    assign rsp_valid = (state_q != StEmpty);
    assign rsp_a     = main_a_q;
    assign rsp_b     = main_b_q;
    assign req_ready = ready_q;
    assign accept    = req_valid & ready_q;
    assign transfer  = rsp_valid & rsp_ready;

    // Buffer next-state: choose where accepted data lands and how the skid drains.
    always_comb begin
        state_d  = state_q;
        main_a_d = main_a_q;
        main_b_d = main_b_q;
        skid_a_d = skid_a_q;
        skid_b_d = skid_b_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d  = StOne;
                    main_a_d = op_a;
                    main_b_d = op_b;
                end
            end
            StOne: begin
                if (accept && transfer) begin
                    main_a_d = op_a;
                    main_b_d = op_b;
                end else if (transfer) begin
                    state_d = StEmpty;
                end else if (accept) begin
                    state_d  = StFull;
                    skid_a_d = op_a;
                    skid_b_d = op_b;
                end
            end
            StFull: begin
                // req_ready is low here, so only a drain can happen.
                if (transfer) begin
                    state_d  = StOne;
                    main_a_d = skid_a_q;
                    main_b_d = skid_b_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Registered so req_ready never depends combinationally on rsp_ready.
        ready_d = (state_d != StFull);
    end

    // Buffer state and data registers; reset drops both entries at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StEmpty;
            main_a_q <= '0;
            main_b_q <= '0;
            skid_a_q <= '0;
            skid_b_q <= '0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            main_a_q <= main_a_d;
            main_b_q <= main_b_d;
            skid_a_q <= skid_a_d;
            skid_b_q <= skid_b_d;
            ready_q  <= ready_d;
        end
    end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Registered dual-operand read side of the 32x32 register file; it is the reader paired with the row-based write side.
- Takes the flattened Q outputs of all register rows, selects two operands per request, and presents them through a valid/ready response interface.
- Write data landing in the same cycle is bypassed into the result, so a response never carries pre-write data for a same-edge write.
- A 2-entry output buffer (main + skid) lets the decode stage stall without losing an accepted request.

Parameters:
- DATA_W, 32, width of each register.
- NUM_REGS, 32, number of register rows.
- ADDR_W, 5, register address width (log2 NUM_REGS).
- ZERO_REG, 31, register index that always reads 0 (XZR); writes to it are ignored for bypass.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- rows  input  NUM_REGS*DATA_W  flattened register file contents; row r occupies bits [r*DATA_W +: DATA_W].
- req_valid  input  1  read request present.
- req_ready  output  1  port can accept a request this cycle.
- req_ra  input  ADDR_W  operand A address.
- req_rb  input  ADDR_W  operand B address.
- wr_en  input  1  write-side enable, qualified with the row select, for the current cycle.
- wr_addr  input  ADDR_W  register being written this cycle.
- wr_data  input  DATA_W  data being written this cycle.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_a  output  DATA_W  operand A value.
- rsp_b  output  DATA_W  operand B value.

Behaviour:
- Reset (reset=0, async):
  - main and skid entries invalid; rsp_valid=0, rsp_a=0, rsp_b=0, req_ready=1.
  - Reset mid-operation discards both buffered entries with no partial response.
- Accept: a request is accepted on a rising edge where req_valid & req_ready.
- Operand select, evaluated in the accept cycle:
  - If addr==ZERO_REG, the value is 0.
  - Else if wr_en & wr_addr==addr, the value is wr_data (bypass).
  - Else the value is the row for that address from rows.
  - A and B are evaluated independently; ra==rb is legal and yields identical values.
- Latency: rsp_valid rises the cycle after accept, with rsp_a/rsp_b stable.
- Response transfer: completes on an edge where rsp_valid & rsp_ready.
- Buffer states:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- req_ready is registered and equals !FULL; it never depends combinationally on rsp_ready.
- Transitions:
  - EMPTY + accept -> ONE; data goes to main.
  - ONE + accept + transfer -> ONE; new data goes to main.
  - ONE + transfer, no accept -> EMPTY.
  - ONE + accept, no transfer -> FULL; new data goes to skid.
  - FULL + transfer -> ONE; skid moves to main. No accept is possible in FULL.
- Ordering: responses leave strictly in acceptance order.
- Snapshot: buffered data is frozen at accept. Writes after acceptance do NOT update held entries; the hazard unit is responsible for stalls beyond this window.
- Hold: while rsp_valid & !rsp_ready, rsp_a/rsp_b/rsp_valid hold unchanged.
- Widths: no arithmetic. Addresses >= NUM_REGS are only possible if NUM_REGS < 2^ADDR_W; they read 0.

Test Plan:
- Reset, then preload row 5 = 0x0000_00A5, row 9 = 0x1234_5678; request ra=5, rb=9 with rsp_ready=1 -> next cycle rsp_valid=1, rsp_a=0x0000_00A5, rsp_b=0x1234_5678.
- Request ra=31, rb=31 while wr_en=1, wr_addr=31, wr_data=0xFFFF_FFFF -> rsp_a=0, rsp_b=0.
- Request ra=7, rb=3 in the same cycle as wr_en=1, wr_addr=7, wr_data=0xDEAD_BEEF, with rows[7]=0 -> rsp_a=0xDEAD_BEEF, rsp_b=rows[3].
- Hold rsp_ready=0; issue requests (1,2) then (3,4) -> req_ready=0 after the second accept, rsp holds the (1,2) data. Raise rsp_ready -> (1,2) transfers, then (3,4) transfers, req_ready returns to 1.
- Back-to-back requests for 8 cycles with rsp_ready=1 -> one response per cycle, in order, req_ready constantly 1.
- Assert reset=0 asynchronously mid-clock while in FULL -> rsp_valid=0 and req_ready=1 immediately, before the next edge; no stale response after release.
